// File: rtl/flex_counter_if.sv
// Control/status bundle for flex_counter: counter controls in, count and rollover flag out.
interface flex_counter_if #(
  parameter int NUM_CNT_BITS = 4
);
  logic                    clear;
  logic                    count_enable;
  logic [NUM_CNT_BITS-1:0] rollover_val;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    rollover_flag;

  modport master (
    output clear, count_enable, rollover_val,
    input  count_out, rollover_flag
  );

  modport slave (
    input  clear, count_enable, rollover_val,
    output count_out, rollover_flag
  );
endinterface

// File: rtl/flex_counter.sv
// Synchronous up-counter with programmable rollover value and registered rollover flag.
// Optional simulation checks are compiled in when FLEX_COUNTER_ASSERT_EN is defined.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input logic           CLK,
  input logic           reset,
  flex_counter_if.slave ctl
);

  localparam int W = NUM_CNT_BITS;

  logic [W-1:0] count_next_p0;
  logic         flag_next_p0;
  logic [W-1:0] count_p1;
  logic         flag_p1;

  // Rollover restarts at 1; a terminal value of 0 pins the count at 0.
  // A count already above a lowered terminal value simply wraps modulo 2^W.
  function automatic logic [W-1:0] advance(input logic [W-1:0] cnt,
                                           input logic [W-1:0] rv,
                                           input logic         en);
    logic [W-1:0] res;
    res = cnt;
    if (en) begin
      if (rv == '0)
        res = '0;
      else if (cnt == rv)
        res = {{(W-1){1'b0}}, 1'b1};
      else
        res = cnt + {{(W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  // ---- p0: next-state computation from sampled inputs ----
  always_comb begin
    count_next_p0 = advance(count_p1, ctl.rollover_val, ctl.count_enable);
    flag_next_p0  = (ctl.rollover_val != '0) && (count_next_p0 == ctl.rollover_val);
  end

  // ---- p1: registered outputs ----
  always_ff @(posedge CLK) begin
    if (reset || ctl.clear) begin
      count_p1 <= '0;
      flag_p1  <= 1'b0;
    end else begin
      count_p1 <= count_next_p0;
      flag_p1  <= flag_next_p0;
    end
  end

  assign ctl.count_out     = count_p1;
  assign ctl.rollover_flag = flag_p1;

`ifdef FLEX_COUNTER_ASSERT_EN
  // Overshoot above the terminal value is only legal while draining a lowered value.
  a_no_overshoot: assert property (@(posedge CLK) disable iff (reset)
    (ctl.count_out > ctl.rollover_val) |->
      (($past(ctl.count_out) > $past(ctl.rollover_val)) ||
       (ctl.rollover_val < $past(ctl.rollover_val))));

  a_flag_matches: assert property (@(posedge CLK) disable iff (reset)
    !$past(ctl.clear) && !$past(reset) |->
      (ctl.rollover_flag == ((ctl.count_out == $past(ctl.rollover_val)) &&
                             ($past(ctl.rollover_val) != '0))));

  a_no_x: assert property (@(posedge CLK) disable iff (reset)
    !$isunknown({ctl.count_out, ctl.rollover_flag}));
`else
`endif

endmodule

// File: tb/tb_flex_counter.sv
// Self-checking bench for flex_counter: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_flex_counter;

  localparam int N   = 4;
  localparam int MOD = 1 << N;

  logic CLK;
  logic reset;

  flex_counter_if #(.NUM_CNT_BITS(N)) bus ();

  flex_counter #(.NUM_CNT_BITS(N)) dut (
    .CLK   (CLK),
    .reset (reset),
    .ctl   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  int m_cnt  = 0;
  bit m_flag = 0;

  // Advance one clock; the model consumes the same inputs the DUT samples.
  task automatic step();
    int rv;
    rv = int'(bus.rollover_val);
    @(posedge CLK);
    if (reset || bus.clear) begin
      m_cnt  = 0;
      m_flag = 0;
    end else begin
      if (bus.count_enable) begin
        if (rv == 0)           m_cnt = 0;
        else if (m_cnt == rv)  m_cnt = 1;
        else                   m_cnt = (m_cnt + 1) % MOD;
      end
      m_flag = (rv != 0) && (m_cnt == rv);
    end
    #1;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.clear = 1'b0; bus.count_enable = 1'b1; bus.rollover_val = 4'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.count_out !== 4'd0 || bus.rollover_flag !== 1'b0)
        $display("FAIL reset cyc%0d: count=%0d flag=%b, want 0/0", i, bus.count_out, bus.rollover_flag);
      else passed++;
    end
    reset = 1'b0;
  endtask

  task automatic test_rollover_seq();
    bus.rollover_val = 4'd5; bus.count_enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int exp_c;
      exp_c = (i % 5) + 1;
      step();
      total++;
      if (bus.count_out !== 4'(exp_c) || bus.rollover_flag !== (exp_c == 5))
        $display("FAIL rollover_seq i%0d: count=%0d flag=%b, want %0d/%b",
                 i, bus.count_out, bus.rollover_flag, exp_c, exp_c == 5);
      else passed++;
    end
  endtask

  task automatic test_hold();
    do_clear();
    bus.rollover_val = 4'd3; bus.count_enable = 1'b1;
    for (int i = 1; i <= 3; i++) step();
    total++;
    if (bus.count_out !== 4'd3 || bus.rollover_flag !== 1'b1)
      $display("FAIL hold_reach: count=%0d flag=%b, want 3/1", bus.count_out, bus.rollover_flag);
    else passed++;
    bus.count_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (bus.count_out !== 4'd3 || bus.rollover_flag !== 1'b1)
        $display("FAIL hold cyc%0d: count=%0d flag=%b, want 3/1", i, bus.count_out, bus.rollover_flag);
      else passed++;
    end
    bus.count_enable = 1'b1;
    step();
    total++;
    if (bus.count_out !== 4'd1 || bus.rollover_flag !== 1'b0)
      $display("FAIL hold_release: count=%0d flag=%b, want 1/0", bus.count_out, bus.rollover_flag);
    else passed++;
  endtask

  task automatic test_clear_enable();
    do_clear();
    bus.rollover_val = 4'd9; bus.count_enable = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.clear = 1'b1;
    step();
    total++;
    if (bus.count_out !== 4'd0 || bus.rollover_flag !== 1'b0)
      $display("FAIL clear_wins: count=%0d flag=%b, want 0/0", bus.count_out, bus.rollover_flag);
    else passed++;
    bus.clear = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (bus.count_out !== 4'(i))
        $display("FAIL clear_release%0d: count=%0d, want %0d", i, bus.count_out, i);
      else passed++;
    end
  endtask

  task automatic test_lowered();
    int exp_seq[$];
    do_clear();
    bus.rollover_val = 4'd12; bus.count_enable = 1'b1;
    for (int i = 0; i < 10; i++) step();
    total++;
    if (bus.count_out !== 4'd10)
      $display("FAIL lowered_setup: count=%0d, want 10", bus.count_out);
    else passed++;
    bus.rollover_val = 4'd7;
    exp_seq = '{11, 12, 13, 14, 15, 0, 1, 2, 3, 4, 5, 6, 7, 1};
    foreach (exp_seq[k]) begin
      step();
      total++;
      if (bus.count_out !== 4'(exp_seq[k]) || bus.rollover_flag !== (exp_seq[k] == 7))
        $display("FAIL lowered k%0d: count=%0d flag=%b, want %0d/%b",
                 k, bus.count_out, bus.rollover_flag, exp_seq[k], exp_seq[k] == 7);
      else passed++;
    end
  endtask

  task automatic test_all_ones();
    do_clear();
    bus.rollover_val = 4'd15; bus.count_enable = 1'b1;
    for (int i = 0; i < 17; i++) begin
      int exp_c;
      exp_c = (i % 15) + 1;
      step();
      total++;
      if (bus.count_out !== 4'(exp_c) || bus.rollover_flag !== (exp_c == 15))
        $display("FAIL all_ones i%0d: count=%0d flag=%b, want %0d/%b",
                 i, bus.count_out, bus.rollover_flag, exp_c, exp_c == 15);
      else passed++;
    end
  endtask

  task automatic test_rv_zero();
    do_clear();
    bus.rollover_val = 4'd6; bus.count_enable = 1'b1;
    step(); step();
    bus.rollover_val = 4'd0;
    step();
    total++;
    if (bus.count_out !== 4'd0 || bus.rollover_flag !== 1'b0)
      $display("FAIL rv_zero_en: count=%0d flag=%b, want 0/0", bus.count_out, bus.rollover_flag);
    else passed++;
    bus.count_enable = 1'b0;
    step();
    total++;
    if (bus.count_out !== 4'd0 || bus.rollover_flag !== 1'b0)
      $display("FAIL rv_zero_hold: count=%0d flag=%b, want 0/0", bus.count_out, bus.rollover_flag);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_clear();
    bus.rollover_val = 4'd9; bus.count_enable = 1'b1;
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    step();
    total++;
    if (bus.count_out !== 4'd0 || bus.rollover_flag !== 1'b0)
      $display("FAIL reset_mid: count=%0d flag=%b, want 0/0", bus.count_out, bus.rollover_flag);
    else passed++;
    reset = 1'b0;
    step();
    total++;
    if (bus.count_out !== 4'd1)
      $display("FAIL reset_mid_restart: count=%0d, want 1", bus.count_out);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset            = ($urandom_range(0, 59) == 0);
      bus.clear        = ($urandom_range(0, 24) == 0);
      bus.count_enable = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 11) == 0)
        bus.rollover_val = 4'($urandom_range(0, MOD - 1));
      step();
      total++;
      if (bus.count_out !== 4'(m_cnt) || bus.rollover_flag !== m_flag)
        $display("FAIL random i%0d: count=%0d flag=%b, want %0d/%b",
                 i, bus.count_out, bus.rollover_flag, m_cnt, m_flag);
      else passed++;
    end
    reset = 1'b0; bus.clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bus.clear = 1'b0; bus.count_enable = 1'b0; bus.rollover_val = '0;
    test_reset();
    test_rollover_seq();
    test_hold();
    test_clear_enable();
    test_lowered();
    test_all_ones();
    test_rv_zero();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
